aes_round_sequencer: RTL and testbench

- Control FSM for an iterative AES round datapath: one shared SubBytes/ShiftRows/MixColumns/AddRoundKey slice reused NR times per block.
- Accepts blocks over a valid/ready handshake and optionally triggers key expansion.
- Drives load, round-enable, round-index, key-index and final-round controls to the datapath and round-key store.
- Presents completion over a valid/ready output handshake. Sits between the block-level interface and the AES round logic cones.

---
 rtl/aes_round_sequencer.sv | 146 ++++++++++++++
 tb/tb_aes_round_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// Control FSM sequencing an iterative AES round datapath: accept, optional key expansion, load, NR rounds, hold.
// Optional macro AES_SEQ_DECRYPT_EN reverses the round-key order for blocks latched with in_decrypt=1.
module aes_round_sequencer #(
  parameter int unsigned NR    = 10,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_new_key,
  input  logic             in_decrypt,
  output logic             key_exp_start,
  input  logic             key_exp_done,
  output logic             dp_load,
  output logic             dp_round_en,
  output logic [IDX_W-1:0] dp_round_idx,
  output logic [IDX_W-1:0] dp_key_idx,
  output logic             dp_final,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_KEYEXP = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_ROUND  = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NR);

  logic [2:0]       state_q, state_n;
  logic [IDX_W-1:0] cnt_q, cnt_n, cnt_inc;
  logic             kstart_n, load_n, en_n, final_n, ov_n;
  logic [IDX_W-1:0] idx_n, key_n;

`ifdef AES_SEQ_DECRYPT_EN
  logic dec_q, dec_n;
`else
  logic unused_decrypt;
  assign unused_decrypt = in_decrypt;
`endif

  assign cnt_inc  = cnt_q + IDX_W'(1);
  assign in_ready = (state_q == S_IDLE) && !rst;
  assign busy     = (state_q != S_IDLE);

  // Next state and next registered outputs; outputs follow the state being entered.
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    kstart_n = 1'b0;
    load_n   = 1'b0;
    en_n     = 1'b0;
    final_n  = 1'b0;
    ov_n     = 1'b0;
    idx_n    = '0;
`ifdef AES_SEQ_DECRYPT_EN
    dec_n    = dec_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
`ifdef AES_SEQ_DECRYPT_EN
          dec_n = in_decrypt;
`endif
          if (in_new_key) begin
            state_n  = S_KEYEXP;
            kstart_n = 1'b1;
          end else begin
            state_n = S_LOAD;
            load_n  = 1'b1;
          end
        end
      end
      S_KEYEXP: begin
        if (key_exp_done) begin
          state_n = S_LOAD;
          load_n  = 1'b1;
        end
      end
      S_LOAD: begin
        state_n = S_ROUND;
        cnt_n   = IDX_W'(1);
        en_n    = 1'b1;
        idx_n   = IDX_W'(1);
        final_n = (LAST == IDX_W'(1));
      end
      S_ROUND: begin
        if (cnt_q == LAST) begin
          state_n = S_HOLD;
          cnt_n   = '0;
          ov_n    = 1'b1;
        end else begin
          cnt_n   = cnt_inc;
          en_n    = 1'b1;
          idx_n   = cnt_inc;
          final_n = (cnt_inc == LAST);
        end
      end
      S_HOLD: begin
        if (out_ready) state_n = S_IDLE;
        else           ov_n    = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
`ifdef AES_SEQ_DECRYPT_EN
    key_n = (load_n || en_n) ? (dec_n ? LAST - idx_n : idx_n) : '0;
`else
    key_n = idx_n;
`endif
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      key_exp_start <= 1'b0;
      dp_load       <= 1'b0;
      dp_round_en   <= 1'b0;
      dp_round_idx  <= '0;
      dp_key_idx    <= '0;
      dp_final      <= 1'b0;
      out_valid     <= 1'b0;
`ifdef AES_SEQ_DECRYPT_EN
      dec_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_n;
      cnt_q         <= cnt_n;
      key_exp_start <= kstart_n;
      dp_load       <= load_n;
      dp_round_en   <= en_n;
      dp_round_idx  <= idx_n;
      dp_key_idx    <= key_n;
      dp_final      <= final_n;
      out_valid     <= ov_n;
`ifdef AES_SEQ_DECRYPT_EN
      dec_q         <= dec_n;
`endif
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed cycle-exact bench for aes_round_sequencer (NR=10); inputs driven after posedge, outputs sampled on negedge.
module tb_aes_round_sequencer;

  localparam int NR    = 10;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_new_key, in_decrypt;
  logic             key_exp_start, key_exp_done;
  logic             dp_load, dp_round_en, dp_final;
  logic [IDX_W-1:0] dp_round_idx, dp_key_idx;
  logic             out_valid, out_ready, busy;

  int n_checks = 0;
  int n_pass   = 0;
  time t_accept;

  always #5 clk = ~clk;

  aes_round_sequencer #(.NR(NR), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_new_key(in_new_key), .in_decrypt(in_decrypt),
    .key_exp_start(key_exp_start), .key_exp_done(key_exp_done),
    .dp_load(dp_load), .dp_round_en(dp_round_en), .dp_round_idx(dp_round_idx),
    .dp_key_idx(dp_key_idx), .dp_final(dp_final),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  function automatic int exp_key(input int r, input bit dec);
`ifdef AES_SEQ_DECRYPT_EN
    return dec ? NR - r : r;
`else
    return r;
`endif
  endfunction

  // One block, checked every cycle; abort_round>0 pulses rst during that round.
  task automatic run_block(input bit new_key, input bit dec, input int done_delay,
                           input int hold, input bit keep_valid, input int abort_round);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", in_ready, 1);
    in_valid   = 1'b1;
    in_new_key = new_key;
    in_decrypt = dec;
    @(posedge clk);
    t_accept = $time;
    #1;
    in_valid   = keep_valid;
    in_new_key = 1'b0;
    in_decrypt = 1'b0;
    @(negedge clk);
    if (new_key) begin
      check("kx_start", key_exp_start, 1);
      check("kx_busy", busy, 1);
      check("kx_in_ready", in_ready, 0);
      if (done_delay == 0) key_exp_done = 1'b1;
      for (int c = 2; c <= 1 + done_delay; c++) begin
        @(negedge clk);
        check("kx_start_once", key_exp_start, 0);
        check("kx_no_load", dp_load, 0);
        if (c == 1 + done_delay) key_exp_done = 1'b1;
      end
      @(posedge clk);
      #1 key_exp_done = 1'b0;
      @(negedge clk);
    end
    check("load", dp_load, 1);
    check("load_en", dp_round_en, 0);
    check("load_idx", dp_round_idx, 0);
    check("load_key", dp_key_idx, exp_key(0, dec));
    for (int r = 1; r <= NR; r++) begin
      @(negedge clk);
      check("rnd_en", dp_round_en, 1);
      check("rnd_load", dp_load, 0);
      check("rnd_idx", dp_round_idx, r);
      check("rnd_key", dp_key_idx, exp_key(r, dec));
      check("rnd_final", dp_final, (r == NR) ? 1 : 0);
      check("rnd_ov", out_valid, 0);
      if (r == abort_round) begin
        rst = 1'b1;
        #1;
        check("abort_en", dp_round_en, 0);
        check("abort_idx", dp_round_idx, 0);
        check("abort_ov", out_valid, 0);
        check("abort_ready", in_ready, 0);
        check("abort_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        return;
      end
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check("hold_ov", out_valid, 1);
      check("hold_en", dp_round_en, 0);
      check("hold_load", dp_load, 0);
      check("hold_final", dp_final, 0);
      check("hold_ready", in_ready, 0);
      out_ready = (h == hold);
    end
    @(negedge clk);
    out_ready = 1'b0;
    check("post_ready", in_ready, 1);
    check("post_ov", out_valid, 0);
    check("post_busy", busy, 0);
  endtask

  initial begin
    time t1;
    bit seen_ov;
    rst = 1'b1; in_valid = 1'b0; in_new_key = 1'b0; in_decrypt = 1'b0;
    key_exp_done = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_ov", out_valid, 0);
    check("rst_load", dp_load, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", in_ready, 1);

    // Plain block, then a second one back-to-back for throughput.
    run_block(1'b0, 1'b0, 0, 0, 1'b0, 0);
    t1 = t_accept;
    run_block(1'b0, 1'b0, 0, 0, 1'b0, 0);
    check("throughput", int'((t_accept - t1) / 10), NR + 3);

    run_block(1'b1, 1'b0, 5, 0, 1'b0, 0);
    run_block(1'b1, 1'b0, 0, 0, 1'b0, 0);
    run_block(1'b0, 1'b0, 0, 7, 1'b0, 0);

    run_block(1'b0, 1'b0, 0, 0, 1'b0, 4);
    seen_ov = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      seen_ov |= out_valid;
    end
    check("abort_no_ov", seen_ov, 0);
    run_block(1'b0, 1'b0, 0, 0, 1'b0, 0);

    run_block(1'b0, 1'b1, 0, 0, 1'b0, 0);

    // in_valid held through KEYEXP/ROUND/HOLD must not start a second block.
    run_block(1'b1, 1'b0, 2, 3, 1'b1, 0);
    seen_ov = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen_ov |= out_valid | busy;
    end
    check("single_block", seen_ov, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
